act_scheduler: RTL and testbench

Shares one `activation_unit` instance between `NUM_REQ` requesters (attention, FFN and norm sub-blocks of the PE core). Requesters present vector jobs over valid/ready; the scheduler arbitrates, drives the unit's `enable`/`activation_type`/`data_i`, and tracks the unit's one-cycle registered latency. It buffers results in a credit-protected output FIFO and returns them in order, tagged with the requester ID.

---
 rtl/act_scheduler.sv | 159 +++++++++++++++
 tb/tb_act_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_scheduler.sv
// Shares one registered activation unit between NUM_REQ requesters: round-robin issue, in-order
// credit-protected result FIFO. Define ACT_SCHED_PRIO0_EN to give requester 0 strict priority.
module act_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [8*NUM_REQ-1:0]                  req_type,
  input  logic [DATA_WIDTH*LANES*NUM_REQ-1:0]   req_data,
  output logic                                  act_enable,
  output logic [7:0]                            act_type,
  output logic [DATA_WIDTH*LANES-1:0]           act_data_o,
  input  logic [DATA_WIDTH*LANES-1:0]           act_data_i,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]            rsp_id,
  output logic [DATA_WIDTH*LANES-1:0]           rsp_data,
  output logic                                  rsp_err,
  output logic                                  busy
);

  localparam int VW  = DATA_WIDTH * LANES;
  localparam int IDW = $clog2(NUM_REQ);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 2;

`ifdef ACT_SCHED_PRIO0_EN
  localparam int             NCAND    = NUM_REQ - 1;
  localparam logic [IDW-1:0] RR_RESET = IDW'(1);
`else
  localparam int             NCAND    = NUM_REQ;
  localparam logic [IDW-1:0] RR_RESET = '0;
`endif

  logic [IDW-1:0] rr_ptr_reg;
  logic           s1_valid_reg, s1_err_reg, s2_valid_reg, s2_err_reg;
  logic [IDW-1:0] s1_id_reg, s2_id_reg;
  logic [7:0]     act_type_reg;
  logic [VW-1:0]  act_data_reg;

  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]    fifo_count_reg;
  logic [VW-1:0]  fifo_data_mem [FIFO_DEPTH];
  logic [IDW-1:0] fifo_id_mem   [FIFO_DEPTH];
  logic           fifo_err_mem  [FIFO_DEPTH];

  logic [7:0]     type_arr [NUM_REQ];
  logic [VW-1:0]  data_arr [NUM_REQ];
  logic [IDW-1:0] cand     [NCAND];
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic [CW-1:0]  used;
  logic           credit_ok, accept, push, pop;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign type_arr[gi]  = req_type[gi*8 +: 8];
      assign data_arr[gi]  = req_data[gi*VW +: VW];
      assign req_ready[gi] = accept && (grant_id == IDW'(gi));
    end
    // cand[k] is the k-th requester in search order starting at rr_ptr
    for (genvar gi = 0; gi < NCAND; gi++) begin : g_cand
`ifdef ACT_SCHED_PRIO0_EN
      assign cand[gi] = IDW'(1 + (int'(rr_ptr_reg) - 1 + gi) % (NUM_REQ - 1));
`else
      assign cand[gi] = IDW'((int'(rr_ptr_reg) + gi) % NUM_REQ);
`endif
    end
  endgenerate

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int k = NCAND - 1; k >= 0; k--) begin
      if (req_valid[cand[k]]) begin
        grant_valid = 1'b1;
        grant_id    = cand[k];
      end
    end
`ifdef ACT_SCHED_PRIO0_EN
    if (req_valid[0]) begin
      grant_valid = 1'b1;
      grant_id    = '0;
    end
`endif
  end

  // Every accepted-but-unpopped job holds a credit, so a push never meets a full FIFO
  assign used      = CW'(s1_valid_reg) + CW'(s2_valid_reg) + CW'(fifo_count_reg);
  assign credit_ok = used < CW'(FIFO_DEPTH);
  assign accept    = grant_valid && credit_ok && !rst;
  assign push      = s2_valid_reg;
  assign pop       = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg     <= RR_RESET;
      s1_valid_reg   <= 1'b0;
      s1_id_reg      <= '0;
      s1_err_reg     <= 1'b0;
      act_type_reg   <= '0;
      act_data_reg   <= '0;
      s2_valid_reg   <= 1'b0;
      s2_id_reg      <= '0;
      s2_err_reg     <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_id_reg    <= grant_id;
        s1_err_reg   <= type_arr[grant_id] > 8'd4;
        act_type_reg <= type_arr[grant_id];
        act_data_reg <= data_arr[grant_id];
`ifdef ACT_SCHED_PRIO0_EN
        if (grant_id != '0)
          rr_ptr_reg <= (grant_id == IDW'(NUM_REQ - 1)) ? IDW'(1) : grant_id + IDW'(1);
`else
        rr_ptr_reg <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
`endif
      end
      s2_valid_reg <= s1_valid_reg;
      s2_id_reg    <= s1_id_reg;
      s2_err_reg   <= s1_err_reg;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + (AW+1)'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - (AW+1)'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  // Storage needs no reset; the pointers decide what is visible
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_mem[wr_ptr_reg] <= act_data_i;
      fifo_id_mem[wr_ptr_reg]   <= s2_id_reg;
      fifo_err_mem[wr_ptr_reg]  <= s2_err_reg;
    end
  end

  assign act_enable = s1_valid_reg;
  assign act_type   = act_type_reg;
  assign act_data_o = act_data_reg;
  assign rsp_valid  = fifo_count_reg != '0;
  assign rsp_id     = rsp_valid ? fifo_id_mem[rd_ptr_reg]   : '0;
  assign rsp_err    = rsp_valid ? fifo_err_mem[rd_ptr_reg]  : 1'b0;
  assign rsp_data   = rsp_valid ? fifo_data_mem[rd_ptr_reg] : '0;
  assign busy       = s1_valid_reg | s2_valid_reg | rsp_valid;

endmodule

// File: tb/tb_act_scheduler.sv
// Randomized/directed bench for act_scheduler with a job-queue reference model and a
// behavioural one-cycle activation unit. Honours ACT_SCHED_PRIO0_EN when defined.
module tb_act_scheduler;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int L  = 4;
  localparam int D  = 4;
  localparam int VW = DW * L;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [8*N-1:0]   req_type;
  logic [VW*N-1:0]  req_data;
  logic             act_enable;
  logic [7:0]       act_type;
  logic [VW-1:0]    act_data_o;
  logic [VW-1:0]    act_data_i = {4{32'hDEADBEEF}};
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [VW-1:0]    rsp_data;
  logic             rsp_err;
  logic             busy;

  act_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .LANES(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_data(req_data), .act_enable(act_enable),
    .act_type(act_type), .act_data_o(act_data_o), .act_data_i(act_data_i),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in activation unit: distinct per-type lane maps, ReLU exact, unknown types pass through
  function automatic logic [VW-1:0] unit_fn(input logic [7:0] t, input logic [VW-1:0] d);
    logic [VW-1:0]     r;
    logic signed [31:0] x;
    r = d;
    for (int l = 0; l < L; l++) begin
      x = d[l*DW +: DW];
      case (t)
        8'd0:    r[l*DW +: DW] = x >>> 1;
        8'd1:    r[l*DW +: DW] = (x < 0) ? 32'sd0 : x;
        8'd2:    r[l*DW +: DW] = x + 32'sd1;
        8'd3:    r[l*DW +: DW] = ~x;
        8'd4:    r[l*DW +: DW] = x >>> 2;
        default: r[l*DW +: DW] = x;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) if (act_enable) act_data_i <= unit_fn(act_type, act_data_o);

  typedef struct {
    int            id;
    logic          err;
    logic [VW-1:0] data;
    int            vis;
  } job_t;

  job_t          q[$];
  int            rr_m, cyc, checks, errors, acc_obs;
  logic          exp_en;
  logic [7:0]    exp_type;
  logic [VW-1:0] exp_adata;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_init();
`ifdef ACT_SCHED_PRIO0_EN
    return 1;
`else
    return 0;
`endif
  endfunction

  // Outstanding jobs (accepted, not yet popped) consume credits; grant follows the arbitration rule
  function automatic int model_grant();
    if (q.size() >= D) return -1;
`ifdef ACT_SCHED_PRIO0_EN
    if (req_valid[0]) return 0;
    for (int k = 0; k < N - 1; k++)
      if (req_valid[1 + (rr_m - 1 + k) % (N - 1)]) return 1 + (rr_m - 1 + k) % (N - 1);
`else
    for (int k = 0; k < N; k++)
      if (req_valid[(rr_m + k) % N]) return (rr_m + k) % N;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    q.delete();
    rr_m      = rr_init();
    exp_en    = 1'b0;
    exp_type  = '0;
    exp_adata = '0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"}, 128'(req_ready), 128'(0));
    check({tag, "_act_enable"}, 128'(act_enable), 128'(0));
    check({tag, "_act_type"}, 128'(act_type), 128'(0));
    check({tag, "_act_data_o"}, act_data_o, 128'(0));
    check({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
    check({tag, "_rsp_id"}, 128'(rsp_id), 128'(0));
    check({tag, "_rsp_err"}, 128'(rsp_err), 128'(0));
    check({tag, "_rsp_data"}, rsp_data, 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
  endtask

  task automatic set_req(input int r, input logic v, input logic [7:0] t, input logic [VW-1:0] d);
    req_valid[r]          = v;
    req_type[r*8 +: 8]    = t;
    req_data[r*VW +: VW]  = d;
  endtask

  task automatic step();
    int            g;
    logic [N-1:0]  er;
    logic          head_vis, pop;
    job_t          j;
    @(negedge clk);
    g  = model_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("req_ready", 128'(req_ready), 128'(er));
    if (|req_ready) acc_obs++;
    head_vis = (q.size() > 0) && (q[0].vis <= cyc);
    check("rsp_valid", 128'(rsp_valid), 128'(head_vis));
    check("busy", 128'(busy), 128'(q.size() > 0));
    check("act_enable", 128'(act_enable), 128'(exp_en));
    check("act_type", 128'(act_type), 128'(exp_type));
    check("act_data_o", act_data_o, exp_adata);
    if (head_vis) begin
      check("rsp_id", 128'(rsp_id), 128'(q[0].id));
      check("rsp_err", 128'(rsp_err), 128'(q[0].err));
      check("rsp_data", rsp_data, q[0].data);
    end
    pop = head_vis && rsp_ready;
    @(posedge clk);
    if (pop) begin
      $display("cyc %0d rsp id=%0d err=%0d data=%h", cyc, q[0].id, q[0].err, q[0].data);
      void'(q.pop_front());
    end
    exp_en = (g >= 0);
    if (g >= 0) begin
      exp_type  = req_type[g*8 +: 8];
      exp_adata = req_data[g*VW +: VW];
      j.id   = g;
      j.err  = exp_type > 8'd4;
      j.data = unit_fn(exp_type, exp_adata);
      j.vis  = cyc + 3;
      q.push_back(j);
      $display("cyc %0d acc id=%0d type=%0d", cyc, g, exp_type);
`ifdef ACT_SCHED_PRIO0_EN
      if (g != 0) rr_m = (g == N - 1) ? 1 : g + 1;
`else
      rr_m = (g + 1) % N;
`endif
    end
    cyc++;
    #1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; acc_obs = 0;
    rst = 1'b1; req_valid = '0; req_type = '0; req_data = '0; rsp_ready = 1'b0;
    model_reset();
    #1;
    check_reset("reset");
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Single ReLU job on requester 2, lanes {5,-3,0,7}
    set_req(2, 1'b1, 8'd1, {32'd7, 32'd0, 32'hFFFF_FFFD, 32'd5});
    step();
    req_valid = '0;
    idle_steps(3);
    check("relu_rsp_valid", 128'(rsp_valid), 128'(1));
    check("relu_rsp_id", 128'(rsp_id), 128'(2));
    check("relu_rsp_data", rsp_data, {32'd7, 32'd0, 32'd0, 32'd5});
    check("relu_rsp_err", 128'(rsp_err), 128'(0));
    rsp_ready = 1'b1;
    idle_steps(3);

    // All requesters valid, consumer always ready
    for (int r = 0; r < N; r++) set_req(r, 1'b1, 8'(r), {4{32'(r * 16 + 1)}});
    idle_steps(16);
    req_valid = '0;
    idle_steps(5);

    // Stalled consumer: requester 1 streams until credits run out
    rsp_ready = 1'b0;
    set_req(1, 1'b1, 8'd2, {32'd4, 32'd3, 32'd2, 32'd1});
    acc_obs = 0;
    idle_steps(8);
    check("stall_accepts", 128'(acc_obs), 128'(4));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    acc_obs = 0;
    idle_steps(5);
    check("one_pop_one_accept", 128'(acc_obs), 128'(1));
    req_valid = '0;
    rsp_ready = 1'b1;
    idle_steps(8);

    // Unsupported type passes data through with rsp_err
    rsp_ready = 1'b0;
    set_req(3, 1'b1, 8'd9, {32'h40, 32'h30, 32'h20, 32'h10});
    step();
    req_valid = '0;
    idle_steps(3);
    check("err_rsp_err", 128'(rsp_err), 128'(1));
    check("err_rsp_data", rsp_data, {32'h40, 32'h30, 32'h20, 32'h10});
    rsp_ready = 1'b1;
    idle_steps(3);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      for (int r = 0; r < N; r++)
        set_req(r, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 9)),
                {$urandom, $urandom, $urandom, $urandom});
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    idle_steps(8);

    // Reset with one buffered job and two in flight
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 8'd1, {4{32'd9}});
    step();
    req_valid = '0;
    idle_steps(2);
    set_req(2, 1'b1, 8'd3, {4{32'd6}});
    idle_steps(2);
    #2 rst = 1'b1;
    #1;
    check_reset("midrst");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; req_valid = '0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    idle_steps(6);
    check("post_rst_busy", 128'(busy), 128'(0));
    check("post_rst_rsp_valid", 128'(rsp_valid), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
